// File: rtl/adder_arbiter_32_bit_if.sv
// Request/response bundle between two requesters and the shared adder arbiter.
// Operands and carry-in belong to the requesters; ack, result, owner and busy belong to the arbiter.
interface adder_arbiter_32_bit_if;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        cin0, cin1;
  logic        ack0, ack1;
  logic [31:0] sum;
  logic        cout;
  logic        owner;
  logic        busy;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  ack0, ack1, sum, cout, owner, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output ack0, ack1, sum, cout, owner, busy
  );
endinterface

// File: rtl/adder_arbiter_32_bit.sv
// Two-requester round-robin arbiter around one shared 32-bit ripple-carry adder.
// Each operation takes three cycles: grant/latch, add/register, ack.

module adder_arbiter_32_bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_arbiter_32_bit #(
  parameter bit PRIO_INIT = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  adder_arbiter_32_bit_if.slave bus
);
  localparam int W = 32;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state;
  logic [W-1:0]   opa, opb;
  logic           opc;
  logic           last;
  logic [W-1:0]   fsum;
  logic           fcout;
  logic           gnt;

  // Each bit keeps its own carry net so the chain is a plain ripple of cells.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic ci, co;
    if (i == 0) begin : g_c0
      assign ci = opc;
    end else begin : g_cn
      assign ci = g_bit[i-1].co;
    end
    adder_arbiter_32_bit_fa u_fa (
      .a (opa[i]),
      .b (opb[i]),
      .ci(ci),
      .s (fsum[i]),
      .co(co)
    );
  end
  assign fcout = g_bit[W-1].co;

  // Contended grant goes to whoever was not served last.
  assign gnt = (bus.req0 & bus.req1) ? ~last : bus.req1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      opc       <= 1'b0;
      last      <= ~PRIO_INIT;
      bus.ack0  <= 1'b0;
      bus.ack1  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.sum   <= '0;
      bus.cout  <= 1'b0;
      bus.owner <= PRIO_INIT;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            bus.owner <= gnt;
            opa       <= gnt ? bus.a1   : bus.a0;
            opb       <= gnt ? bus.b1   : bus.b0;
            opc       <= gnt ? bus.cin1 : bus.cin0;
            bus.busy  <= 1'b1;
            state     <= ADD;
          end
        end
        ADD: begin
          bus.sum  <= fsum;
          bus.cout <= fcout;
          state    <= DONE;
        end
        DONE: begin
          bus.ack0 <= ~bus.owner;
          bus.ack1 <= bus.owner;
          last     <= bus.owner;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adder_arbiter_32_bit.md
ADDER_ARBITER_32_BIT -- requirements
Module: adder_arbiter_32_bit

Interface
REQ-001 Parameter: PRIO_INIT, default 0, requester preferred on the first contended grant after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 req0  input  1  requester 0 operation request; held high until ack0.
REQ-005 a0, b0  input  32 each  requester 0 operands; stable while req0 high.
REQ-006 cin0  input  1  requester 0 carry-in.
REQ-007 req1, a1, b1, cin1  input  1/32/32/1  requester 1 request, operands and carry-in; same rules as requester 0.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 sum  output  32  result of the last completed operation.
REQ-010 cout  output  1  carry out of bit 31 of the last completed operation.
REQ-011 owner  output  1  index of the requester currently or most recently granted.
REQ-012 busy  output  1  high in states ADD and DONE.

Function
REQ-013 The block SHALL contain exactly one 32-bit ripple-carry adder (full-adder chain, bit 0 carry-in from the latched cin) shared by both requesters.
REQ-014 The FSM SHALL have states IDLE, ADD and DONE; all outputs are registered.
REQ-015 IDLE: no req -> stay IDLE; any req -> grant, latch granted a, b and cin into operand registers, load owner, go to ADD.
REQ-016 Only req0 high -> grant 0; only req1 high -> grant 1; both high -> grant the requester not served last (round-robin pointer).
REQ-017 ADD: register adder output into sum and cout on the exiting edge, go to DONE; the unsettled adder output is never visible on sum.
REQ-018 DONE: assert ack[owner] for exactly one cycle, set last-served pointer to owner, go to IDLE on the next edge.
REQ-019 Latency: req sampled at edge E0 in IDLE -> sum/cout valid after E1 -> ack high for the cycle between E2 and E3; sum/cout and ack are visible together in that cycle.
REQ-020 Throughput: one operation per 3 cycles; a req still high in IDLE after its ack SHALL be treated as a new request.
REQ-021 Arithmetic: sum = (a + b + cin) mod 2^32; cout = bit 32 of the unsigned sum; no overflow flag.
REQ-022 Operand or req changes after the grant edge SHALL NOT affect the in-flight operation; a req dropped during ADD/DONE still receives ack.
REQ-023 A requester not granted SHALL keep its request pending with no ack; the loser of a contended grant SHALL be granted on the next IDLE, giving worst-case wait 3 cycles.
REQ-024 sum and cout SHALL hold their value between completions; ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-025 With rst_n low at a rising edge: state = IDLE, ack0 = ack1 = 0, busy = 0, sum = 0, cout = 0, owner = PRIO_INIT, last-served pointer = not PRIO_INIT.
REQ-026 Reset asserted in ADD or DONE SHALL abort the operation: no ack is issued and sum/cout are cleared to 0.
REQ-027 Reset SHALL take precedence over all requests in the same cycle.

Verification
REQ-028 Single request: req0 with a0 = 0x0000_0005, b0 = 0x0000_0003, cin0 = 0 -> ack0 pulses 1 cycle, 2 edges after the grant; sum = 0x0000_0008, cout = 0.
REQ-029 Wrap-around: req1 with a1 = 0xFFFF_FFFF, b1 = 0x0000_0000, cin1 = 1 -> sum = 0x0000_0000, cout = 1, ack1 pulse, ack0 = 0.
REQ-030 Contention: req0 and req1 high together after reset (PRIO_INIT = 0) -> requester 0 served first and requester 1 next; the order alternates 0,1,0,1 while both stay high.
REQ-031 Operand hijack: a0 changed from 0x10 to 0x20 one cycle after the grant (b0 = 0x1) -> sum = 0x0000_0011.
REQ-032 Reset mid-op: rst_n low during ADD -> no ack; sum = 0 and busy = 0 the cycle after; the next request completes normally.
REQ-033 Random: 10k random operand/req sequences checked against a reference model of (a + b + cin), with ack exclusivity and no requester starvation.
